io_controller: RTL and testbench

IO_CONTROLLER -- requirements
Module: io_controller

---
 rtl/io_controller_pkg.sv | 37 +++
 rtl/io_controller_debounce.sv | 45 ++++
 rtl/io_controller.sv | 160 ++++++++++++++++
 tb/tb_io_controller.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/io_controller_pkg.sv
// Shared definitions for the CPU I/O controller: op encodings, FSM states
// and the active-low 7-segment digit table.
package io_controller_pkg;

  localparam int unsigned OP_W  = 2;
  localparam int unsigned SEG_W = 7;

  localparam logic [OP_W-1:0] OP_NONE = 2'b00;
  localparam logic [OP_W-1:0] OP_IN   = 2'b01;
  localparam logic [OP_W-1:0] OP_OUT  = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_WAIT_IN = 2'd1,
    ST_DONE    = 2'd2
  } in_state_t;

  // Segment order {g,f,e,d,c,b,a}, low = lit; non-decimal codes blank the digit.
  function automatic logic [SEG_W-1:0] seg_decode(input logic [3:0] digit);
    logic [SEG_W-1:0] seg;
    case (digit)
      4'd0:    seg = 7'h40;
      4'd1:    seg = 7'h79;
      4'd2:    seg = 7'h24;
      4'd3:    seg = 7'h30;
      4'd4:    seg = 7'h19;
      4'd5:    seg = 7'h12;
      4'd6:    seg = 7'h02;
      4'd7:    seg = 7'h78;
      4'd8:    seg = 7'h00;
      4'd9:    seg = 7'h10;
      default: seg = 7'h7F;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/io_controller_debounce.sv
// Push-button conditioning: 2-flop synchronizer, level debouncer and
// rising-edge detector producing a single-cycle press pulse.
module io_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_button,
  output logic o_press_c
);

  localparam int unsigned CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_d;
  logic [CW-1:0] r_cnt;

  // Counter tracks consecutive samples disagreeing with the accepted level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_d <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_button;
      r_s2   <= r_s1;
      r_db_d <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press_c = r_db & ~r_db_d;

endmodule

// File: rtl/io_controller.sv
// CPU-facing I/O block: switch capture on IN (stalls until a debounced press)
// and double-dabble BCD conversion of OUT values onto 7-segment digits.
module io_controller
  import io_controller_pkg::*;
#(
  parameter int unsigned DATA_WIDTH      = 32,
  parameter int unsigned SW_WIDTH        = 18,
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [SW_WIDTH-1:0]         switches,
  input  logic                        button,
  input  logic [1:0]                  op_io,
  input  logic [DATA_WIDTH-1:0]       data_disp,
  output logic [DATA_WIDTH-1:0]       s_io,
  output logic                        wait_flag,
  output logic                        disp_busy,
  output logic                        disp_ovf,
  output logic [SEG_W*NUM_DIGITS-1:0] displays
);

  localparam int unsigned BCD_W = 4 * NUM_DIGITS;
  localparam int unsigned CNT_W = $clog2(DATA_WIDTH + 1);

  in_state_t             r_state;
  in_state_t             w_next;
  logic                  w_press;
  logic                  w_wait;
  logic                  w_capture;
  logic [DATA_WIDTH-1:0] r_s_io;

  logic [DATA_WIDTH-1:0] r_bin;
  logic [BCD_W-1:0]      r_bcd;
  logic [BCD_W-1:0]      w_adj;
  logic [BCD_W-1:0]      w_shift;
  logic                  w_out_bit;
  logic                  r_ovf_acc;
  logic [CNT_W-1:0]      r_cnt;
  logic                  r_busy;
  logic                  r_done;
  logic [BCD_W-1:0]      r_digits;
  logic                  r_ovf;

  io_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_button (button),
    .o_press_c(w_press)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Input FSM: presses outside WAIT_IN are ignored; leaving IN aborts the wait.
  always_comb begin
    w_next    = r_state;
    w_wait    = 1'b0;
    w_capture = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (op_io == OP_IN) begin
          w_wait = 1'b1;
          w_next = ST_WAIT_IN;
        end
      end
      ST_WAIT_IN: begin
        if (op_io != OP_IN) begin
          w_next = ST_IDLE;
        end else begin
          w_wait = 1'b1;
          if (w_press) begin
            w_capture = 1'b1;
            w_next    = ST_DONE;
          end
        end
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  // The stall is combinational from op_io, so it must also be masked by reset.
  assign wait_flag = w_wait & rst_n;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_io <= '0;
    end else if (w_capture) begin
      r_s_io <= DATA_WIDTH'(switches);
    end
  end

  // One double-dabble step: add 3 to digits >= 5, then shift in the next MSB.
  always_comb begin
    w_adj = r_bcd;
    for (int k = 0; k < int'(NUM_DIGITS); k++) begin
      if (r_bcd[4*k +: 4] >= 4'd5) begin
        w_adj[4*k +: 4] = r_bcd[4*k +: 4] + 4'd3;
      end
    end
    w_shift   = {w_adj[BCD_W-2:0], r_bin[DATA_WIDTH-1]};
    w_out_bit = w_adj[BCD_W-1];
  end

  // A new OUT always restarts; a 1 leaving the top digit marks overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_bin     <= '0;
      r_bcd     <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= '0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
    end else if (op_io == OP_OUT) begin
      r_bin     <= data_disp;
      r_bcd     <= '0;
      r_ovf_acc <= 1'b0;
      r_cnt     <= CNT_W'(DATA_WIDTH);
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else if (r_busy) begin
      r_bin     <= r_bin << 1;
      r_bcd     <= w_shift;
      r_ovf_acc <= r_ovf_acc | w_out_bit;
      r_cnt     <= r_cnt - CNT_W'(1);
      r_busy    <= (r_cnt != CNT_W'(1));
      r_done    <= (r_cnt == CNT_W'(1));
    end else begin
      r_done    <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_digits <= '0;
      r_ovf    <= 1'b0;
    end else if (r_done) begin
      r_digits <= r_bcd;
      r_ovf    <= r_ovf_acc;
    end
  end

  for (genvar g = 0; g < int'(NUM_DIGITS); g++) begin : g_seg
    assign displays[SEG_W*g +: SEG_W] = seg_decode(r_digits[4*g +: 4]);
  end

  assign s_io      = r_s_io;
  assign disp_busy = r_busy;
  assign disp_ovf  = r_ovf;

endmodule

// File: tb/tb_io_controller.sv
// Self-checking bench for io_controller: cycle-level behavioural model plus
// directed scenarios with literal expectations.
module tb_io_controller;

  localparam int unsigned DW  = 32;
  localparam int unsigned SW  = 18;
  localparam int unsigned ND  = 4;
  localparam int unsigned DEB = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [SW-1:0] switches = '0;
  logic          button = 1'b0;
  logic [1:0]    op_io = 2'b00;
  logic [DW-1:0] data_disp = '0;
  logic [DW-1:0] s_io;
  logic          wait_flag;
  logic          disp_busy;
  logic          disp_ovf;
  logic [7*ND-1:0] displays;

  int n_cmp = 0;
  int n_bad = 0;

  io_controller #(
    .DATA_WIDTH(DW), .SW_WIDTH(SW), .NUM_DIGITS(ND), .DEBOUNCE_CYCLES(DEB)
  ) dut (
    .clk(clk), .rst_n(rst_n), .switches(switches), .button(button),
    .op_io(op_io), .data_disp(data_disp), .s_io(s_io), .wait_flag(wait_flag),
    .disp_busy(disp_busy), .disp_ovf(disp_ovf), .displays(displays)
  );

  initial forever #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  int              m_st = 0;          // 0 idle, 1 waiting for press, 2 done
  logic [DW-1:0]   m_sio = '0;
  bit              m_press = 1'b0;
  bit              m_db = 1'b0;
  bit              bq [DEB+1];        // raw button samples, newest first
  longint unsigned m_pend = 0;
  int              m_left = 0;        // edges until the pending value is shown
  longint unsigned m_disp = 0;
  bit              m_ovf = 1'b0;

  function automatic logic [7*ND-1:0] exp_segs(input longint unsigned v);
    logic [6:0] tbl [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                             7'h12, 7'h02, 7'h78, 7'h00, 7'h10};
    logic [7*ND-1:0] r;
    longint unsigned x;
    r = '0;
    x = v;
    for (int k = 0; k < int'(ND); k++) begin
      r[7*k +: 7] = tbl[int'(x % 10)];
      x = x / 10;
    end
    return r;
  endfunction

  function automatic bit exp_wait();
    return rst_n && (op_io == 2'b01) && (m_st == 0 || m_st == 1);
  endfunction

  initial begin
    for (int k = 0; k <= int'(DEB); k++) bq[k] = 1'b0;
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_st = 0; m_sio = '0; m_press = 1'b0; m_db = 1'b0;
        for (int k = 0; k <= int'(DEB); k++) bq[k] = 1'b0;
        m_pend = 0; m_left = 0; m_disp = 0; m_ovf = 1'b0;
      end else begin
        bit flip;
        case (m_st)
          0: if (op_io == 2'b01) m_st = 1;
          1: if (op_io != 2'b01) m_st = 0;
             else if (m_press) begin m_sio = DW'(switches); m_st = 2; end
          default: m_st = 0;
        endcase
        // level accepted once the last DEB synchronized samples all disagree
        flip = 1'b1;
        for (int k = 1; k <= int'(DEB); k++) if (bq[k] == m_db) flip = 1'b0;
        m_press = 1'b0;
        if (flip) begin m_db = !m_db; m_press = m_db; end
        for (int k = int'(DEB); k >= 1; k--) bq[k] = bq[k-1];
        bq[0] = button;
        if (m_left > 0) begin
          m_left--;
          if (m_left == 0) begin m_disp = m_pend % 10000; m_ovf = (m_pend >= 10000); end
        end
        if (op_io == 2'b10) begin m_pend = data_disp; m_left = DW + 1; end
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Every-cycle comparison against the model
  initial forever begin
    @(negedge clk);
    check("wait_flag", 64'(wait_flag), 64'(exp_wait()));
    check("s_io", 64'(s_io), 64'(m_sio));
    check("disp_busy", 64'(disp_busy), 64'(rst_n && m_left > 1));
    check("disp_ovf", 64'(disp_ovf), 64'(m_ovf));
    check("displays", 64'(displays), 64'(exp_segs(m_disp)));
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic tick(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic do_out(input logic [DW-1:0] v);
    data_disp = v; op_io = 2'b10; tick(1); op_io = 2'b00;
  endtask

  // ---------------- directed scenarios ----------------
  initial begin
    int cnt;
    int caps;
    int seen;
    tick(3);
    rst_n = 1'b1;
    tick(2);
    check("reset_s_io", 64'(s_io), 64'h0);
    check("reset_disp", 64'(displays), 64'({4{7'h40}}));
    check("reset_wait", 64'(wait_flag), 64'h0);
    check("reset_busy", 64'(disp_busy), 64'h0);

    // IN with a long stall, then a clean press
    switches = 18'h2A5F5; op_io = 2'b01;
    tick(100);
    check("in_stall", 64'(wait_flag), 64'h1);
    button = 1'b1;
    cnt = 0;
    for (int i = 0; i < 40 && wait_flag; i++) begin tick(1); cnt++; end
    op_io = 2'b00;
    check("in_latency_ok", 64'(cnt >= 1 && cnt <= int'(DEB) + 4), 64'h1);
    tick(1);
    check("in_capture", 64'(s_io), 64'h0002A5F5);
    button = 1'b0;
    tick(25);

    // bouncing button, then held: one capture, re-issued IN stays stalled
    switches = 18'h00155; op_io = 2'b01;
    caps = 0;
    for (int i = 0; i < 40; i++) begin
      button = ((i / 3) % 2 == 0);
      tick(1);
      if (op_io == 2'b01 && !wait_flag) caps++;
    end
    button = 1'b1;
    for (int i = 0; i < 60; i++) begin
      tick(1);
      if (op_io == 2'b01 && !wait_flag) caps++;
    end
    check("bounce_one_capture", 64'(caps), 64'd1);
    check("bounce_s_io", 64'(s_io), 64'h00000155);
    check("held_still_wait", 64'(wait_flag), 64'h1);
    button = 1'b0;
    tick(25);
    check("released_still_wait", 64'(wait_flag), 64'h1);
    switches = 18'h3FFFF; button = 1'b1;
    for (int i = 0; i < 40 && wait_flag; i++) tick(1);
    op_io = 2'b00;
    tick(1);
    check("second_capture", 64'(s_io), 64'h0003FFFF);
    button = 1'b0;
    tick(25);

    // press while idle is discarded; abort leaves s_io alone
    button = 1'b1; tick(25); button = 1'b0; tick(25);
    switches = 18'h00001; op_io = 2'b01;
    tick(10);
    check("idle_press_dropped", 64'(wait_flag), 64'h1);
    op_io = 2'b00;
    tick(1);
    check("abort_wait", 64'(wait_flag), 64'h0);
    check("abort_s_io", 64'(s_io), 64'h0003FFFF);

    // OUT 1234
    do_out(32'd1234);
    cnt = 0;
    for (int i = 0; i < 100 && disp_busy; i++) begin cnt++; tick(1); end
    check("busy_cycles", 64'(cnt), 64'd32);
    check("disp_before_load", 64'(displays), 64'({4{7'h40}}));
    tick(2);
    check("disp_1234", 64'(displays), 64'({7'h79, 7'h24, 7'h30, 7'h19}));
    check("ovf_1234", 64'(disp_ovf), 64'h0);

    // OUT 98765 overflows
    do_out(32'd98765);
    tick(40);
    check("disp_8765", 64'(displays), 64'({7'h00, 7'h78, 7'h02, 7'h12}));
    check("ovf_98765", 64'(disp_ovf), 64'h1);

    // restart: 42 issued 10 cycles into 9999
    do_out(32'd9999);
    tick(9);
    do_out(32'd42);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      tick(1);
      if (displays == {4{7'h10}}) seen++;
    end
    check("no_9999", 64'(seen), 64'd0);
    check("disp_0042", 64'(displays), 64'({7'h40, 7'h40, 7'h19, 7'h24}));
    check("ovf_0042", 64'(disp_ovf), 64'h0);

    // reset mid-WAIT_IN
    op_io = 2'b01;
    tick(5);
    rst_n = 1'b0;
    #1;
    check("rst_wait", 64'(wait_flag), 64'h0);
    check("rst_s_io", 64'(s_io), 64'h0);
    check("rst_disp", 64'(displays), 64'({4{7'h40}}));
    tick(2);
    op_io = 2'b00; rst_n = 1'b1;
    tick(3);
    check("post_rst_s_io", 64'(s_io), 64'h0);

    // reset mid-conversion
    do_out(32'd5555);
    tick(5);
    rst_n = 1'b0;
    #1;
    check("rst_busy", 64'(disp_busy), 64'h0);
    tick(2);
    rst_n = 1'b1;
    tick(45);
    check("post_rst_disp", 64'(displays), 64'({4{7'h40}}));
    check("post_rst_busy", 64'(disp_busy), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
